// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB colour-fade sequencer: FSM state encoding,
// default duty width, step handling and the per-channel ramp arithmetic.
package rgb_pkg;

    // Default duty width; the top-level DUTY_W parameter must match this
    // value because the step function below is sized from it.
    localparam int DUTY_W = 8;

    // Width of the step field carried by a colour command.
    localparam int STEP_W = 4;

    // A requested step of zero ramps at this rate instead.
    localparam logic [STEP_W-1:0] STEP_ZERO_AS = 4'd1;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FADE = 2'd1,
        ST_HOLD = 2'd2
    } fade_state_e;

    // Move one channel a single tick toward its target. If the remaining
    // distance fits within the step, land exactly on the target; otherwise
    // move by the full step in the direction of the target. Because the
    // step never exceeds the distance in the second case, the result can
    // neither overshoot nor wrap.
    function automatic logic [DUTY_W-1:0] step_toward(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic [STEP_W-1:0] step
    );
        logic signed [DUTY_W:0] diff;
        logic        [DUTY_W:0] mag;
        logic        [DUTY_W:0] step_ext;
        logic        [DUTY_W-1:0] nxt;
        diff     = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag      = diff[DUTY_W] ? $unsigned(-diff) : $unsigned(diff);
        step_ext = {{(DUTY_W + 1 - STEP_W){1'b0}}, step};
        if (mag <= step_ext) begin
            nxt = tgt;
        end else if (diff[DUTY_W]) begin
            nxt = cur - step_ext[DUTY_W-1:0];
        end else begin
            nxt = cur + step_ext[DUTY_W-1:0];
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rgb_fade_tick.sv
// Fade-rate prescaler: counts 0..TICK_DIV-1 and raises a one-cycle tick
// while the count sits at its final value. A synchronous clear restarts
// the count so the first tick lands exactly TICK_DIV cycles later.
module rgb_fade_tick
    import rgb_pkg::*;
#(
    parameter int TICK_DIV = 65536
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             tick_q;
    logic             tick_d;

    // Next count: clear on request, wrap at the top, otherwise increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {CNT_W{1'b0}};
        end else if (count_q == CNT_MAX) begin
            count_d = {CNT_W{1'b0}};
        end else begin
            count_d = count_q + {{(CNT_W - 1){1'b0}}, 1'b1};
        end
        tick_d = (count_d == CNT_MAX);
    end

    // Count and registered tick flag with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= {CNT_W{1'b0}};
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/rgb_fade_ctrl.sv
// Colour-fade sequencer: accepts one colour command at a time, ramps the
// three duty registers toward the target once per prescaler tick, holds
// for the requested number of ticks and then flags completion.
module rgb_fade_ctrl
    import rgb_pkg::*;
#(
    parameter int TICK_DIV = 65536,
    parameter int DUTY_W   = rgb_pkg::DUTY_W,
    parameter int HOLD_W   = 8
) (
    input  logic              clk_24MHz_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [DUTY_W-1:0] cmd_r_i,
    input  logic [DUTY_W-1:0] cmd_g_i,
    input  logic [DUTY_W-1:0] cmd_b_i,
    input  logic [3:0]        cmd_step_i,
    input  logic [HOLD_W-1:0] cmd_hold_i,
    input  logic              abort_i,
    output logic [DUTY_W-1:0] duty_r_o,
    output logic [DUTY_W-1:0] duty_g_o,
    output logic [DUTY_W-1:0] duty_b_o,
    output logic              busy_o,
    output logic              done_o
);

    fade_state_e       state_q, state_d;
    logic [DUTY_W-1:0] duty_r_q, duty_r_d;
    logic [DUTY_W-1:0] duty_g_q, duty_g_d;
    logic [DUTY_W-1:0] duty_b_q, duty_b_d;
    logic [DUTY_W-1:0] tgt_r_q, tgt_r_d;
    logic [DUTY_W-1:0] tgt_g_q, tgt_g_d;
    logic [DUTY_W-1:0] tgt_b_q, tgt_b_d;
    logic [3:0]        step_q, step_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              fin_q, fin_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              ready_s;
    logic              accept_s;
    logic              tick_s;
    logic [DUTY_W-1:0] nxt_r_s;
    logic [DUTY_W-1:0] nxt_g_s;
    logic [DUTY_W-1:0] nxt_b_s;
    logic              all_at_tgt_s;

    // A command is only taken while idle, and never in a cycle that is
    // being reset or aborted.
    assign ready_s     = (state_q == ST_IDLE) & ~rst_i & ~abort_i;
    assign accept_s    = cmd_valid_i & ready_s;
    assign cmd_ready_o = ready_s;

    rgb_fade_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_i  (clk_24MHz_i),
        .rst_i  (rst_i),
        .clr_i  (accept_s),
        .tick_o (tick_s)
    );

    // Candidate duties for the next tick and the "fade complete" test.
    assign nxt_r_s      = step_toward(duty_r_q, tgt_r_q, step_q);
    assign nxt_g_s      = step_toward(duty_g_q, tgt_g_q, step_q);
    assign nxt_b_s      = step_toward(duty_b_q, tgt_b_q, step_q);
    assign all_at_tgt_s = (nxt_r_s == tgt_r_q) & (nxt_g_s == tgt_g_q) &
                          (nxt_b_s == tgt_b_q);

    // State register and all datapath flops, synchronous reset.
    always_ff @(posedge clk_24MHz_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            duty_r_q   <= {DUTY_W{1'b0}};
            duty_g_q   <= {DUTY_W{1'b0}};
            duty_b_q   <= {DUTY_W{1'b0}};
            tgt_r_q    <= {DUTY_W{1'b0}};
            tgt_g_q    <= {DUTY_W{1'b0}};
            tgt_b_q    <= {DUTY_W{1'b0}};
            step_q     <= 4'd0;
            hold_q     <= {HOLD_W{1'b0}};
            hold_cnt_q <= {HOLD_W{1'b0}};
            fin_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_r_q   <= duty_r_d;
            duty_g_q   <= duty_g_d;
            duty_b_q   <= duty_b_d;
            tgt_r_q    <= tgt_r_d;
            tgt_g_q    <= tgt_g_d;
            tgt_b_q    <= tgt_b_d;
            step_q     <= step_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            fin_q      <= fin_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_d = ST_FADE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FADE: begin
                    if (tick_s && all_at_tgt_s) begin
                        if (hold_q == {HOLD_W{1'b0}}) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_HOLD;
                        end
                    end else begin
                        state_d = ST_FADE;
                    end
                end
                ST_HOLD: begin
                    if (tick_s && (hold_cnt_q == {{(HOLD_W - 1){1'b0}}, 1'b1})) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Datapath updates: command latch, per-tick ramp and hold countdown.
    // An abort leaves every register untouched, freezing the duties.
    always_comb begin
        duty_r_d   = duty_r_q;
        duty_g_d   = duty_g_q;
        duty_b_d   = duty_b_q;
        tgt_r_d    = tgt_r_q;
        tgt_g_d    = tgt_g_q;
        tgt_b_d    = tgt_b_q;
        step_d     = step_q;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        if (abort_i) begin
            hold_cnt_d = hold_cnt_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        tgt_r_d = cmd_r_i;
                        tgt_g_d = cmd_g_i;
                        tgt_b_d = cmd_b_i;
                        step_d  = (cmd_step_i == 4'd0) ? STEP_ZERO_AS : cmd_step_i;
                        hold_d  = cmd_hold_i;
                    end else begin
                        step_d = step_q;
                    end
                end
                ST_FADE: begin
                    if (tick_s) begin
                        duty_r_d = nxt_r_s;
                        duty_g_d = nxt_g_s;
                        duty_b_d = nxt_b_s;
                        if (all_at_tgt_s) begin
                            hold_cnt_d = hold_q;
                        end else begin
                            hold_cnt_d = hold_cnt_q;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q;
                    end
                end
                ST_HOLD: begin
                    if (tick_s) begin
                        hold_cnt_d = hold_cnt_q - {{(HOLD_W - 1){1'b0}}, 1'b1};
                    end else begin
                        hold_cnt_d = hold_cnt_q;
                    end
                end
                default: begin
                    hold_cnt_d = hold_cnt_q;
                end
            endcase
        end
    end

    // Status outputs: busy follows the state one cycle late, completion is
    // remembered for one cycle and then pulsed on done, so the pulse lands
    // in the first cycle where busy is already low.
    always_comb begin
        fin_d  = (state_q != ST_IDLE) && (state_d == ST_IDLE) && !abort_i;
        done_d = fin_q && !abort_i;
        busy_d = (state_q != ST_IDLE) && !abort_i;
    end

    assign duty_r_o = duty_r_q;
    assign duty_g_o = duty_g_q;
    assign duty_b_o = duty_b_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Self-checking bench for rgb_fade_ctrl with TICK_DIV=4. Expected duties
// and timing come from a closed-form model: after k ticks each channel has
// moved min(k*step, distance) toward its target; the fade takes as many
// ticks as the slowest channel needs (at least one), followed by `hold`
// ticks, with done one cycle after the final tick edge.
module tb_rgb_fade_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic [7:0] cmd_r_i = 8'd0, cmd_g_i = 8'd0, cmd_b_i = 8'd0;
    logic [3:0] cmd_step_i = 4'd0;
    logic [7:0] cmd_hold_i = 8'd0;
    logic       abort_i = 1'b0;
    logic [7:0] duty_r_o, duty_g_o, duty_b_o;
    logic       busy_o, done_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int cur_r = 0, cur_g = 0, cur_b = 0;
    int exp_done_cyc = -10;
    bit bb_expect = 1'b0;
    int nx_r, nx_g, nx_b, nx_s, nx_h;

    rgb_fade_ctrl #(.TICK_DIV(TD), .DUTY_W(8), .HOLD_W(8)) dut (
        .clk_24MHz_i (clk),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_r_i     (cmd_r_i),
        .cmd_g_i     (cmd_g_i),
        .cmd_b_i     (cmd_b_i),
        .cmd_step_i  (cmd_step_i),
        .cmd_hold_i  (cmd_hold_i),
        .abort_i     (abort_i),
        .duty_r_o    (duty_r_o),
        .duty_g_o    (duty_g_o),
        .duty_b_o    (duty_b_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int absv(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Channel value after k ticks from s0 toward t at rate st.
    function automatic int fade(input int s0, input int t, input int st, input int k);
        int d;
        d = t - s0;
        if (absv(d) <= k * st) return t;
        return (d > 0) ? s0 + k * st : s0 - k * st;
    endfunction

    // Ticks spent fading: slowest channel, never fewer than one.
    function automatic int nticks(input int r0, g0, b0, r, g, b, st);
        int n, m;
        n = 1;
        m = (absv(r - r0) + st - 1) / st; if (m > n) n = m;
        m = (absv(g - g0) + st - 1) / st; if (m > n) n = m;
        m = (absv(b - b0) + st - 1) / st; if (m > n) n = m;
        return n;
    endfunction

    // Offer a command, wait for acceptance, then follow it cycle by cycle
    // against the model. stop_c >= 0 stops observing after that many cycles
    // (used when the caller interrupts the command).
    task automatic run_cmd(input int r, g, b, st, hd, input bit nxt, input int stop_c);
        int s, n, e, acc, last, k, c, er, eg, eb, sr, sg, sb;
        bit got;
        bit exp_b, exp_d, exp_rd;
        cmd_r_i = 8'(r); cmd_g_i = 8'(g); cmd_b_i = 8'(b);
        cmd_step_i = 4'(st); cmd_hold_i = 8'(hd); cmd_valid_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (cmd_ready_o === 1'b1) begin got = 1'b1; break; end
            @(negedge clk);
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL accept_timeout ready=%b want 1", cmd_ready_o);
            cmd_valid_i = 1'b0;
            return;
        end
        @(posedge clk); #1;
        acc = cyc;
        total++;
        if (done_o !== (acc == exp_done_cyc)) begin
            bad++;
            $display("FAIL done_at_accept got=%b want=%b", done_o, (acc == exp_done_cyc));
        end
        if (bb_expect) begin
            total++;
            if (acc != exp_done_cyc) begin
                bad++;
                $display("FAIL b2b_accept_cycle got=%0d want=%0d", acc, exp_done_cyc);
            end
        end
        s = (st == 0) ? 1 : st;
        sr = cur_r; sg = cur_g; sb = cur_b;
        n = nticks(sr, sg, sb, r, g, b, s);
        e = TD * (n + hd);
        @(negedge clk);
        if (nxt) begin
            cmd_r_i = 8'(nx_r); cmd_g_i = 8'(nx_g); cmd_b_i = 8'(nx_b);
            cmd_step_i = 4'(nx_s); cmd_hold_i = 8'(nx_h); cmd_valid_i = 1'b1;
        end else begin
            cmd_valid_i = 1'b0;
        end
        last = (stop_c >= 0) ? stop_c : (nxt ? e : e + 2);
        k = 0;
        for (int j = 1; j <= last; j++) begin
            @(posedge clk); #1;
            c = cyc - acc;
            k = c / TD; if (k > n) k = n;
            er = fade(sr, r, s, k); eg = fade(sg, g, s, k); eb = fade(sb, b, s, k);
            exp_b = (c <= e); exp_d = (c == e + 1); exp_rd = (c >= e);
            total++; if (duty_r_o !== 8'(er)) begin bad++; $display("FAIL duty_r c=%0d got=%0d want=%0d", c, duty_r_o, er); end
            total++; if (duty_g_o !== 8'(eg)) begin bad++; $display("FAIL duty_g c=%0d got=%0d want=%0d", c, duty_g_o, eg); end
            total++; if (duty_b_o !== 8'(eb)) begin bad++; $display("FAIL duty_b c=%0d got=%0d want=%0d", c, duty_b_o, eb); end
            total++; if (busy_o !== exp_b) begin bad++; $display("FAIL busy c=%0d got=%b want=%b", c, busy_o, exp_b); end
            total++; if (done_o !== exp_d) begin bad++; $display("FAIL done c=%0d got=%b want=%b", c, done_o, exp_d); end
            total++; if (cmd_ready_o !== exp_rd) begin bad++; $display("FAIL ready c=%0d got=%b want=%b", c, cmd_ready_o, exp_rd); end
        end
        if (stop_c < 0) begin
            cur_r = r; cur_g = g; cur_b = b;
            exp_done_cyc = acc + e + 1;
        end else begin
            cur_r = fade(sr, r, s, k); cur_g = fade(sg, g, s, k); cur_b = fade(sb, b, s, k);
            exp_done_cyc = -10;
        end
        bb_expect = nxt && (stop_c < 0);
    endtask

    task automatic test_reset;
        rst_i = 1'b1; cmd_valid_i = 1'b1;
        cmd_r_i = 8'd55; cmd_g_i = 8'd66; cmd_b_i = 8'd77; cmd_step_i = 4'd3; cmd_hold_i = 8'd1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (duty_r_o !== 8'd0 || duty_g_o !== 8'd0 || duty_b_o !== 8'd0) begin
            bad++; $display("FAIL reset_duties got=%0d/%0d/%0d want=0/0/0", duty_r_o, duty_g_o, duty_b_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done_o); end
        total++; if (cmd_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", cmd_ready_o); end
        @(negedge clk);
        rst_i = 1'b0; cmd_valid_i = 1'b0;
        #1;
        total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%b want=1", cmd_ready_o); end
        cur_r = 0; cur_g = 0; cur_b = 0; exp_done_cyc = -10; bb_expect = 1'b0;
    endtask

    // Basic ramp with hold, while the saturating bidirectional command
    // waits behind it and must be taken exactly when done pulses.
    task automatic test_basic_back_to_back;
        nx_r = 0; nx_g = 255; nx_b = 3; nx_s = 0; nx_h = 1;
        run_cmd(10, 0, 0, 4, 2, 1'b1, -1);
        run_cmd(0, 255, 3, 0, 1, 1'b0, -1);
    endtask

    task automatic test_noop;
        run_cmd(cur_r, cur_g, cur_b, int'($urandom_range(0, 15)), 0, 1'b0, -1);
    endtask

    task automatic test_random;
        int tr[8], tg[8], tbl[8], ts[8], th[8];
        bit bb[8];
        for (int i = 0; i < 8; i++) begin
            tr[i] = $urandom_range(0, 255); tg[i] = $urandom_range(0, 255);
            tbl[i] = $urandom_range(0, 255); ts[i] = $urandom_range(0, 15);
            th[i] = $urandom_range(0, 4); bb[i] = ($urandom_range(0, 1) == 1) && (i < 7);
        end
        for (int i = 0; i < 8; i++) begin
            if (bb[i]) begin
                nx_r = tr[i+1]; nx_g = tg[i+1]; nx_b = tbl[i+1]; nx_s = ts[i+1]; nx_h = th[i+1];
            end
            run_cmd(tr[i], tg[i], tbl[i], ts[i], th[i], bb[i], -1);
        end
    endtask

    task automatic test_abort;
        run_cmd(0, 0, 0, 15, 0, 1'b0, -1);
        run_cmd(20, 0, 0, 2, 0, 1'b0, 12);
        total++; if (duty_r_o !== 8'd6) begin bad++; $display("FAIL abort_setup got=%0d want=6", duty_r_o); end
        @(negedge clk);
        abort_i = 1'b1; cmd_valid_i = 1'b1;
        cmd_r_i = 8'd9; cmd_g_i = 8'd9; cmd_b_i = 8'd9; cmd_step_i = 4'd3; cmd_hold_i = 8'd1;
        #1;
        total++; if (cmd_ready_o !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b want=0", cmd_ready_o); end
        @(posedge clk); #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy_o); end
        total++; if (duty_r_o !== 8'd6) begin bad++; $display("FAIL abort_freeze got=%0d want=6", duty_r_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done_o); end
        @(negedge clk);
        abort_i = 1'b0;
        #1;
        total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL abort_not_taken got=%b want=1", cmd_ready_o); end
        cur_r = 6; cur_g = 0; cur_b = 0; exp_done_cyc = -10; bb_expect = 1'b0;
        run_cmd(9, 9, 9, 3, 1, 1'b0, -1);
    endtask

    task automatic test_reset_hold;
        run_cmd(200, 50, 7, 15, 3, 1'b0, 58);
        total++; if (busy_o !== 1'b1 || duty_r_o !== 8'd200) begin
            bad++; $display("FAIL hold_setup busy=%b r=%0d want 1/200", busy_o, duty_r_o); end
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk); #1;
        total++; if (duty_r_o !== 8'd0 || duty_g_o !== 8'd0 || duty_b_o !== 8'd0) begin
            bad++; $display("FAIL rst_hold_duties got=%0d/%0d/%0d want=0/0/0", duty_r_o, duty_g_o, duty_b_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_hold_busy got=%b want=0", busy_o); end
        total++; if (cmd_ready_o !== 1'b0) begin bad++; $display("FAIL rst_hold_ready got=%b want=0", cmd_ready_o); end
        @(negedge clk);
        rst_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            total++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                bad++; $display("FAIL rst_hold_quiet i=%0d done=%b busy=%b want 0/0", i, done_o, busy_o); end
        end
        cur_r = 0; cur_g = 0; cur_b = 0; exp_done_cyc = -10; bb_expect = 1'b0;
        run_cmd(5, 5, 5, 1, 0, 1'b0, -1);
    endtask

    initial begin
        test_reset;
        test_basic_back_to_back;
        test_noop;
        test_random;
        test_abort;
        test_reset_hold;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb_fade_ctrl.md
Name: rgb_fade_ctrl

Overview:
Colour-fade sequencer for the RGB PWM LED driver. Accepts one colour command at a time over a valid/ready handshake: target R/G/B duty, step size and hold time. Ramps the three 8-bit duty registers toward the target at a prescaled tick rate, then holds, then reports completion. The duty outputs feed the downstream PWM comparator directly; the LED-driving logic stays outside this block.

Parameters:
TICK_DIV, 65536, clock cycles per fade tick (~366 Hz at 24 MHz); minimum 2
DUTY_W, 8, duty width per channel
HOLD_W, 8, hold-counter width in ticks

Ports:
clk_24MHz_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when valid&ready
cmd_r_i / cmd_g_i / cmd_b_i  in  DUTY_W each  target duties
cmd_step_i  in  4  duty change per tick; 0 treated as 1
cmd_hold_i  in  HOLD_W  ticks to hold at target
abort_i  in  1  abandon current command
duty_r_o / duty_g_o / duty_b_o  out  DUTY_W each  current duties (registered)
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset (sync, rst_i=1): duties 0, state IDLE, prescaler 0, hold_cnt 0, done_o 0. cmd_ready_o = (state==IDLE) & !rst_i & !abort_i.
- Prescaler counts 0..TICK_DIV-1 and wraps. tick = (count==TICK_DIV-1). Cleared to 0 on command accept, so the first tick comes exactly TICK_DIV cycles after the accept edge.
- States: IDLE, FADE, HOLD.
- IDLE: on valid&ready, latch target, step and hold, then go to FADE.
- FADE, on tick, per channel:
  - d = target - cur, 9-bit signed.
  - If |d| <= step: next = target; otherwise next = cur ± step.
  - No wrap-around or overflow is possible.
- FADE exit, on the tick where all three next values equal their targets (including the already-equal case, which exits on the first tick):
  - hold==0: go to IDLE.
  - Otherwise: go to HOLD with hold_cnt = hold.
- HOLD: on tick, decrement hold_cnt. On the tick with hold_cnt==1, go to IDLE. HOLD lasts exactly `hold` ticks.
- done_o: high for exactly the first cycle in IDLE after a normal completion. Never pulses after abort or reset.
- abort_i: priority below reset, above everything else. From any state, next edge: IDLE, duties frozen at their current values, no done pulse. A cmd_valid_i coincident with abort_i is not accepted.
- Duties change only on FADE ticks or reset. Duties hold between ticks and in HOLD/IDLE.
- Commands offered while busy stall (cmd_ready_o=0) and must be held stable by the source until accepted.
- busy_o and done_o are never both high.

Decomposition:
- Shared package rgb_pkg: state encodings (IDLE/FADE/HOLD), DUTY_W default, step-zero-to-one rule constant.
- Sub-module rgb_fade_tick: prescaler with sync clear input and tick output, parameter TICK_DIV.
- Per-channel step arithmetic is a function in rgb_pkg, instantiated three times.

Test Plan:
All scenarios use TICK_DIV=4.
1. Reset: rst_i high 2 cycles with cmd_valid_i=1 -> duties 0/0/0, busy_o 0, done_o 0, cmd_ready_o 0 during reset and 1 the cycle after release.
2. Basic fade: cmd (10,0,0) step 4 hold 2 accepted at edge T -> duty_r_o 4 at T+4, 8 at T+8, 10 at T+12. HOLD through the ticks at T+16 and T+20. done_o single pulse and busy_o low from T+21. A second cmd held valid during this time is accepted only at T+21.
3. Bidirectional and saturating: from (10,0,0), cmd (0,255,3) step 0 -> r falls 1/tick and reaches 0 at tick 10. g rises 1/tick. b reaches 3 at tick 3 and stays there. HOLD entered at tick 255 with no overshoot or wrap.
4. No-op command: target equals current, hold 0 -> duties unchanged, IDLE plus done_o at the first tick +1 cycle (T+5).
5. Abort mid-fade: abort_i pulsed when duty_r_o=6 during a ramp to 20, with cmd_valid_i=1 in the same cycle -> next edge busy_o 0 and duty_r_o stays 6. No done pulse; command not accepted until the following cycle.
6. Reset mid-HOLD: rst_i for 1 cycle during HOLD of (200,50,7) -> next edge duties 0, IDLE, no done_o. Prescaler restarts from 0.
